// File: rtl/sysid_checker.sv
// sysid_checker: Avalon-MM read master that fetches the sysid ID and timestamp words
// after reset or on request, and reports pass, mismatch or timeout.
module sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1355118694,
   parameter int unsigned TIMEOUT_CYCLES     = 255,
   parameter int unsigned MAX_RETRIES        = 2,
   parameter bit          AUTO_START         = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic [3:0]  retry_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ID,
      S_RD_TS,
      S_GAP,
      S_CHECK,
      S_DONE
   } state_t;

   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

   state_t      r_state;
   logic [15:0] r_wait;
   logic        r_auto;
   logic        w_start;
   logic        w_expired;
   logic        w_retry_ok;

   assign w_start    = start | r_auto;
   // Compared before the increment: the stalled cycle that would make the count reach
   // TIMEOUT_CYCLES is the last one the read strobe is held.
   assign w_expired  = avm_waitrequest && (r_wait == WAIT_LAST);
   assign w_retry_ok = retry_count < RETRY_MAX;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_wait      <= '0;
         r_auto      <= AUTO_START;
         avm_address <= 1'b0;
         avm_read    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         id_ok       <= 1'b0;
         ts_ok       <= 1'b0;
         timeout     <= 1'b0;
         id_value    <= '0;
         ts_value    <= '0;
         retry_count <= '0;
      end else begin
         r_auto <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_start) begin
                  done        <= 1'b0;
                  id_ok       <= 1'b0;
                  ts_ok       <= 1'b0;
                  timeout     <= 1'b0;
                  retry_count <= '0;
                  busy        <= 1'b1;
                  avm_read    <= 1'b1;
                  avm_address <= 1'b0;
                  r_wait      <= '0;
                  r_state     <= S_RD_ID;
               end
            end
            S_RD_ID, S_RD_TS: begin
               if (!avm_waitrequest) begin
                  r_wait <= '0;
                  if (r_state == S_RD_ID) begin
                     id_value    <= avm_readdata;
                     avm_address <= 1'b1;
                     r_state     <= S_RD_TS;
                  end else begin
                     ts_value <= avm_readdata;
                     avm_read <= 1'b0;
                     r_state  <= S_CHECK;
                  end
               end else if (w_expired) begin
                  avm_read <= 1'b0;
                  if (w_retry_ok) begin
                     if (retry_count != 4'hF) retry_count <= retry_count + 4'd1;
                     r_state <= S_GAP;
                  end else begin
                     timeout <= 1'b1;
                     id_ok   <= 1'b0;
                     ts_ok   <= 1'b0;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     r_state <= S_DONE;
                  end
               end else begin
                  r_wait <= r_wait + 16'd1;
               end
            end
            S_GAP: begin
               // avm_address still names the read that timed out
               avm_read <= 1'b1;
               r_wait   <= '0;
               r_state  <= avm_address ? S_RD_TS : S_RD_ID;
            end
            S_CHECK: begin
               id_ok   <= (id_value == EXPECTED_ID);
               ts_ok   <= (ts_value == EXPECTED_TIMESTAMP);
               done    <= 1'b1;
               busy    <= 1'b0;
               r_state <= S_DONE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: stalling Avalon slave plus an outcome model computed from the
// per-attempt stall plan; directed boot/retry/reset cases followed by random checks.
module tb_sysid_checker;

   localparam int          TO     = 8;
   localparam int          MR     = 2;
   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'd1355118694;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        busy, done, id_ok, ts_ok, timeout;
   logic [31:0] id_value, ts_value;
   logic [3:0]  retry_count;

   int checks = 0;
   int errors = 0;

   // slave contents, attempt plan and monitor results
   logic [31:0] sl_id, sl_ts;
   logic [31:0] m_id, m_ts;
   int          plan[$];
   int          stall_q[$];
   int          rises, unstable, cyc;
   int          xfer_addr[$];
   int          xfer_cyc[$];

   sysid_checker #(
      .EXPECTED_ID       (EXP_ID),
      .EXPECTED_TIMESTAMP(EXP_TS),
      .TIMEOUT_CYCLES    (TO),
      .MAX_RETRIES       (MR),
      .AUTO_START        (1'b1)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .avm_address    (avm_address),
      .avm_read       (avm_read),
      .avm_waitrequest(avm_waitrequest),
      .avm_readdata   (avm_readdata),
      .busy           (busy),
      .done           (done),
      .id_ok          (id_ok),
      .ts_ok          (ts_ok),
      .timeout        (timeout),
      .id_value       (id_value),
      .ts_value       (ts_value),
      .retry_count    (retry_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Slave: each read attempt takes the next stall count from stall_q, then completes.
   initial begin
      int  remaining;
      bit  in_att, last_rd, last_wt, last_addr;
      remaining = 0; in_att = 0; last_rd = 0; last_wt = 0; last_addr = 0;
      rises = 0; unstable = 0; cyc = 0;
      avm_waitrequest = 1'b0;
      avm_readdata    = '0;
      forever begin
         @(posedge clock);
         #1;
         cyc++;
         if (last_rd && !last_wt) begin
            in_att = 0;
            xfer_addr.push_back(int'(last_addr));
            xfer_cyc.push_back(cyc);
         end else if (last_rd && last_wt && remaining > 0) begin
            remaining--;
         end
         if (!avm_read) in_att = 0;
         if (avm_read && !last_rd) rises++;
         if (last_rd && last_wt && avm_read && (avm_address != last_addr)) unstable++;
         if (avm_read && !in_att) begin
            in_att    = 1;
            remaining = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
         end
         avm_waitrequest = avm_read && (remaining > 0);
         avm_readdata    = avm_address ? sl_ts : sl_id;
         last_rd   = avm_read;
         last_wt   = avm_waitrequest;
         last_addr = avm_address;
      end
   end

   // One complete check: started by reset release (auto start) or by a start pulse.
   task automatic do_check(input string tag, input bit via_reset, input bit poke);
      int idx, lat, rtr, rs, nx, n, s;
      bit to, fin;
      if (via_reset) begin
         reset = 1'b1;
         start = 1'b1;
         @(posedge clock);
         @(negedge clock);
         check({tag, "_rst_flags"}, {avm_read, avm_address, busy, done, id_ok, ts_ok, timeout, retry_count}, '0);
         check({tag, "_rst_id"}, id_value, '0);
         check({tag, "_rst_ts"}, ts_value, '0);
         m_id = '0;
         m_ts = '0;
      end
      // reference outcome from the attempt plan
      idx = 0; lat = 0; rtr = 0; rs = 1; nx = 0; to = 0;
      for (int p = 0; p < 2 && !to; p++) begin
         fin = 0;
         while (!fin) begin
            s = (idx < plan.size()) ? plan[idx] : 0;
            idx++;
            if (s < TO) begin
               lat += s + 1;
               nx++;
               fin = 1;
               if (p == 0) m_id = sl_id;
               else        m_ts = sl_ts;
            end else begin
               lat += TO;
               if (rtr < MR) begin
                  rtr++;
                  lat++;
                  rs++;
               end else begin
                  to  = 1;
                  fin = 1;
               end
            end
         end
      end
      if (!to) lat++;

      stall_q = plan;
      rises = 0;
      unstable = 0;
      xfer_addr.delete();
      xfer_cyc.delete();
      if (via_reset) begin
         reset = 1'b0;
         start = 1'b0;
      end else begin
         start = 1'b1;
      end
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      check({tag, "_go"}, {busy, done, id_ok, ts_ok, timeout, retry_count}, 64'h100);
      n = 0;
      while (n < 600) begin
         @(posedge clock);
         n++;
         @(negedge clock);
         start = (poke && n == 2) ? 1'b1 : 1'b0;
         if (done) break;
      end
      start = 1'b0;
      check({tag, "_lat"}, n, lat);
      check({tag, "_end"}, {done, busy}, 2'b10);
      check({tag, "_id_ok"}, id_ok, !to && (m_id == EXP_ID));
      check({tag, "_ts_ok"}, ts_ok, !to && (m_ts == EXP_TS));
      check({tag, "_timeout"}, timeout, to);
      check({tag, "_retries"}, retry_count, rtr);
      check({tag, "_id_val"}, id_value, m_id);
      check({tag, "_ts_val"}, ts_value, m_ts);
      check({tag, "_attempts"}, rises, rs);
      check({tag, "_stable"}, unstable, 0);
      check({tag, "_xfers"}, xfer_addr.size(), nx);
      @(posedge clock);
      @(negedge clock);
      check({tag, "_hold"}, {done, busy, avm_read}, 3'b100);
   endtask

   initial begin
      int r;
      reset = 1'b1;
      start = 1'b0;
      sl_id = EXP_ID;
      sl_ts = EXP_TS;
      m_id  = '0;
      m_ts  = '0;
      repeat (2) @(negedge clock);

      // boot: auto-started zero-wait check, addr 0 then addr 1 on consecutive cycles
      plan = '{0, 0};
      do_check("boot", 1'b1, 1'b0);
      check("boot_order", {xfer_addr[0][0], xfer_addr[1][0]}, 2'b01);
      check("boot_consec", xfer_cyc[1] - xfer_cyc[0], 1);

      // explicit start, zero wait, start poked in the cycle DONE is entered
      plan = '{0, 0};
      do_check("zw", 1'b0, 1'b1);

      sl_id = 32'd5;
      plan = '{0, 0};
      do_check("badid", 1'b0, 1'b0);
      sl_id = EXP_ID;

      plan = '{4, 4};
      do_check("wait4", 1'b0, 1'b1);

      plan = '{1000, 1000, 1000};
      do_check("stuck", 1'b0, 1'b0);

      plan = '{1000, 0, 1000, 3};
      do_check("retry_ok", 1'b0, 1'b0);

      // reset while the timestamp read is stalled, then auto restart
      plan = '{0, 1000};
      stall_q = plan;
      start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(negedge clock);
      check("midrst_stalled", {avm_read, avm_address, avm_waitrequest}, 3'b111);
      plan = '{0, 0};
      do_check("midrst", 1'b1, 1'b0);

      for (int t = 0; t < 40; t++) begin
         sl_id = ($urandom_range(0, 2) == 0) ? $urandom : EXP_ID;
         sl_ts = ($urandom_range(0, 2) == 0) ? $urandom : EXP_TS;
         plan.delete();
         for (int a = 0; a < 6; a++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)      plan.push_back(int'($urandom_range(0, 4)));
            else if (r < 8) plan.push_back(int'($urandom_range(5, 7)));
            else            plan.push_back(TO + int'($urandom_range(0, 3)));
         end
         do_check("rnd", 1'b0, $urandom_range(0, 1) == 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
